// File: rtl/my_and_16_bist.sv
// BIST engine for a 16-bit AND unit: two LFSRs drive operand pairs, and each
// result is checked against a locally computed AND after a settle delay.
module my_and_16_bist #(
  parameter int          NUM_VECTORS = 16,
  parameter int          SETTLE      = 1,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] dut_out,
  output logic [15:0] dut_a,
  output logic [15:0] dut_b,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_count,
  output logic [15:0] first_fail_idx,
  output logic [15:0] first_fail_a,
  output logic [15:0] first_fail_b,
  output logic [15:0] first_fail_out
);

  localparam logic [15:0] LAST_IDX   = 16'(NUM_VECTORS - 1);
  localparam logic [3:0]  SETTLE_CNT = 4'(SETTLE);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

  state_t      state, next_state;
  logic [15:0] lfsr_a, lfsr_b;
  logic [15:0] idx;
  logic [3:0]  cnt;
  logic        have_fail;
  logic        mismatch;
  logic        last_vec;

  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  endfunction

  assign mismatch = (dut_out != (dut_a & dut_b));
  assign last_vec = (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) next_state = (SETTLE_CNT == 4'd0) ? S_CHECK : S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt <= 4'd1) next_state = S_CHECK;
      end
      S_CHECK: begin
        if (last_vec)                 next_state = S_DONE;
        else if (SETTLE_CNT == 4'd0)  next_state = S_CHECK;
        else                          next_state = S_SETTLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // dut_a/dut_b mirror the LFSRs but stay at zero out of reset until a run loads them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_a         <= SEED;
      lfsr_b         <= ~SEED;
      dut_a          <= '0;
      dut_b          <= '0;
      cnt            <= '0;
      idx            <= '0;
      err_count      <= '0;
      have_fail      <= 1'b0;
      first_fail_idx <= '0;
      first_fail_a   <= '0;
      first_fail_b   <= '0;
      first_fail_out <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            lfsr_a         <= SEED;
            lfsr_b         <= ~SEED;
            dut_a          <= SEED;
            dut_b          <= ~SEED;
            cnt            <= SETTLE_CNT;
            idx            <= '0;
            err_count      <= '0;
            have_fail      <= 1'b0;
            first_fail_idx <= '0;
            first_fail_a   <= '0;
            first_fail_b   <= '0;
            first_fail_out <= '0;
          end
        end
        S_SETTLE: begin
          cnt <= cnt - 4'd1;
        end
        S_CHECK: begin
          if (mismatch) begin
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            if (!have_fail) begin
              have_fail      <= 1'b1;
              first_fail_idx <= idx;
              first_fail_a   <= dut_a;
              first_fail_b   <= dut_b;
              first_fail_out <= dut_out;
            end
          end
          if (!last_vec) begin
            idx    <= idx + 16'd1;
            lfsr_a <= lfsr_next(lfsr_a);
            lfsr_b <= lfsr_next(lfsr_b);
            dut_a  <= lfsr_next(lfsr_a);
            dut_b  <= lfsr_next(lfsr_b);
            cnt    <= SETTLE_CNT;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy = (state == S_SETTLE) || (state == S_CHECK);
    done = (state == S_DONE);
    pass = (state == S_DONE) && (err_count == 8'd0);
  end

endmodule

// File: tb/tb_my_and_16_bist.sv
// Scoreboard bench for my_and_16_bist: three instances (defaults, 300 vectors,
// zero settle) driven by a behavioural unit model with selectable faults.
module tb_my_and_16_bist;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
  } vec_t;

  typedef struct {
    logic [7:0]  err;
    logic        pass;
    logic [15:0] idx;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] out;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_v   [3];
  logic [15:0] dut_out_v [3];
  logic [15:0] dut_a_v   [3];
  logic [15:0] dut_b_v   [3];
  logic        busy_v    [3];
  logic        done_v    [3];
  logic        pass_v    [3];
  logic [7:0]  err_v     [3];
  logic [15:0] ffi_v     [3];
  logic [15:0] ffa_v     [3];
  logic [15:0] ffb_v     [3];
  logic [15:0] ffo_v     [3];
  int          mode_v    [3];
  logic [15:0] mask_v    [3];

  vec_t cyc_q [3][$];
  res_t res_q [3][$];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  function automatic int cfg_nv(input int i);
    return (i == 1) ? 300 : 16;
  endfunction

  function automatic int cfg_st(input int i);
    return (i == 2) ? 0 : 1;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  endfunction

  // Unit-under-test model: good AND, stuck-at-1 bit0, inverted, or random xor fault.
  function automatic logic [15:0] unit_model(input logic [15:0] a, input logic [15:0] b,
                                             input int md, input logic [15:0] mask);
    case (md)
      1:       return (a & b) | 16'h0001;
      2:       return ~(a & b);
      3:       return (a & b) ^ (mask & (a ^ b));
      default: return a & b;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_unit
    assign dut_out_v[g] = unit_model(dut_a_v[g], dut_b_v[g], mode_v[g], mask_v[g]);
  end

  my_and_16_bist u0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .dut_out(dut_out_v[0]),
    .dut_a(dut_a_v[0]), .dut_b(dut_b_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .pass(pass_v[0]), .err_count(err_v[0]), .first_fail_idx(ffi_v[0]),
    .first_fail_a(ffa_v[0]), .first_fail_b(ffb_v[0]), .first_fail_out(ffo_v[0]));

  my_and_16_bist #(.NUM_VECTORS(300)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .dut_out(dut_out_v[1]),
    .dut_a(dut_a_v[1]), .dut_b(dut_b_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .pass(pass_v[1]), .err_count(err_v[1]), .first_fail_idx(ffi_v[1]),
    .first_fail_a(ffa_v[1]), .first_fail_b(ffb_v[1]), .first_fail_out(ffo_v[1]));

  my_and_16_bist #(.SETTLE(0)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .dut_out(dut_out_v[2]),
    .dut_a(dut_a_v[2]), .dut_b(dut_b_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .pass(pass_v[2]), .err_count(err_v[2]), .first_fail_idx(ffi_v[2]),
    .first_fail_a(ffa_v[2]), .first_fail_b(ffb_v[2]), .first_fail_out(ffo_v[2]));

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic reportFail(input string name);
    checks++;
    fails++;
    $display("[TB] FAIL %s", name);
  endtask

  // Monitors: every busy cycle must present the next expected operand pair;
  // the rising edge of done must present the expected run summary.
  for (genvar g = 0; g < 3; g++) begin : g_mon
    logic done_prev = 1'b0;
    always @(negedge clk) begin
      if (busy_v[g]) begin
        if (cyc_q[g].size() == 0) begin
          reportFail($sformatf("u%0d busy beyond expected vector cycles", g));
        end else begin
          vec_t v;
          v = cyc_q[g].pop_front();
          checkOutput($sformatf("u%0d dut_a", g), 32'(dut_a_v[g]), 32'(v.a));
          checkOutput($sformatf("u%0d dut_b", g), 32'(dut_b_v[g]), 32'(v.b));
        end
      end
      if (done_v[g] && !done_prev) begin
        if (res_q[g].size() == 0) begin
          reportFail($sformatf("u%0d unexpected done", g));
        end else begin
          res_t r;
          r = res_q[g].pop_front();
          checkOutput($sformatf("u%0d err_count", g),      32'(err_v[g]), 32'(r.err));
          checkOutput($sformatf("u%0d pass", g),           32'(pass_v[g]), 32'(r.pass));
          checkOutput($sformatf("u%0d first_fail_idx", g), 32'(ffi_v[g]), 32'(r.idx));
          checkOutput($sformatf("u%0d first_fail_a", g),   32'(ffa_v[g]), 32'(r.a));
          checkOutput($sformatf("u%0d first_fail_b", g),   32'(ffb_v[g]), 32'(r.b));
          checkOutput($sformatf("u%0d first_fail_out", g), 32'(ffo_v[g]), 32'(r.out));
          checkOutput($sformatf("u%0d busy at done", g),   32'(busy_v[g]), 32'd0);
          checkOutput($sformatf("u%0d vector cycles left", g), 32'(cyc_q[g].size()), 32'd0);
        end
      end
      done_prev = done_v[g];
    end
  end

  // Reference: walk the operand sequence, expand each vector to SETTLE+1 busy
  // cycles, and tally mismatches of the modelled unit.
  task automatic buildModel(input int i, input int md, input logic [15:0] mask);
    logic [15:0] a, b, o;
    res_t r;
    int   n;
    a = 16'hACE1;
    b = ~a;
    n = 0;
    r = '{err: 8'd0, pass: 1'b0, idx: 16'd0, a: 16'd0, b: 16'd0, out: 16'd0};
    mode_v[i] = md;
    mask_v[i] = mask;
    for (int v = 0; v < cfg_nv(i); v++) begin
      for (int c = 0; c <= cfg_st(i); c++) cyc_q[i].push_back('{a: a, b: b});
      o = unit_model(a, b, md, mask);
      if (o != (a & b)) begin
        if (n == 0) begin
          r.idx = 16'(v);
          r.a   = a;
          r.b   = b;
          r.out = o;
        end
        n++;
      end
      a = lfsr_step(a);
      b = lfsr_step(b);
    end
    r.err  = (n > 255) ? 8'd255 : 8'(n);
    r.pass = (n == 0);
    res_q[i].push_back(r);
  endtask

  task automatic pulseStart(input int i);
    @(negedge clk);
    start_v[i] = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
    checkOutput($sformatf("u%0d busy after start", i), 32'(busy_v[i]), 32'd1);
    checkOutput($sformatf("u%0d done after start", i), 32'(done_v[i]), 32'd0);
    checkOutput($sformatf("u%0d pass after start", i), 32'(pass_v[i]), 32'd0);
  endtask

  task automatic applyStimulus(input int i, input int md, input logic [15:0] mask, input int extra);
    int  limit;
    logic seen;
    buildModel(i, md, mask);
    pulseStart(i);
    limit = cfg_nv(i) * (cfg_st(i) + 1) + 20;
    seen  = 1'b0;
    for (int c = 1; c < limit && !seen; c++) begin
      if (done_v[i]) seen = 1'b1;
      else begin
        start_v[i] = (extra > 0) && (c == extra);
        @(negedge clk);
      end
    end
    start_v[i] = 1'b0;
    if (!done_v[i]) reportFail($sformatf("u%0d timeout waiting for done", i));
    @(negedge clk);
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, " busy"},      32'(busy_v[0]), 32'd0);
    checkOutput({tag, " done"},      32'(done_v[0]), 32'd0);
    checkOutput({tag, " pass"},      32'(pass_v[0]), 32'd0);
    checkOutput({tag, " err_count"}, 32'(err_v[0]),  32'd0);
    checkOutput({tag, " dut_a"},     32'(dut_a_v[0]), 32'd0);
    checkOutput({tag, " dut_b"},     32'(dut_b_v[0]), 32'd0);
    checkOutput({tag, " ff_idx"},    32'(ffi_v[0]), 32'd0);
    checkOutput({tag, " ff_a"},      32'(ffa_v[0]), 32'd0);
    checkOutput({tag, " ff_b"},      32'(ffb_v[0]), 32'd0);
    checkOutput({tag, " ff_out"},    32'(ffo_v[0]), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      mode_v[i]  = 0;
      mask_v[i]  = 16'h0000;
    end
    repeat (2) @(negedge clk);
    checkCleared("reset");
    rst_n = 1'b1;

    $display("[TB] good unit, defaults");
    applyStimulus(0, 0, 16'h0000, 0);
    $display("[TB] stuck-at-1 bit0");
    applyStimulus(0, 1, 16'h0000, 0);
    $display("[TB] zero settle, good unit");
    applyStimulus(2, 0, 16'h0000, 0);
    $display("[TB] 300 vectors, inverted unit (saturation)");
    applyStimulus(1, 2, 16'h0000, 0);
    $display("[TB] random xor faults");
    for (int k = 0; k < 4; k++) begin
      logic [15:0] m;
      m = 16'($urandom);
      if (m[3:0] == 4'h0) m = 16'h0000;
      applyStimulus(k % 3, 3, m, 0);
    end
    $display("[TB] start pulsed while busy");
    applyStimulus(0, 1, 16'h0000, 5);
    applyStimulus(2, 0, 16'h0000, 3);

    $display("[TB] reset mid-run");
    buildModel(0, 1, 16'h0000);
    pulseStart(0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkCleared("midrun reset");
    rst_n = 1'b1;
    cyc_q[0].delete();
    res_q[0].delete();
    applyStimulus(0, 1, 16'h0000, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
